skinny_sbox_layer_dom1_ctrl: RTL and testbench

Sequences the 16-byte SKINNY-128 SubCells layer of a two-share (DOM1) state through NUM_SBOX instances of the non-pipelined DOM1 sbox8 core (skinny_sbox8_dom1_non_pipelined_de).
- That core requires its shares and refresh mask to be held stable for LATENCY cycles. This block provides that guarantee.
- It fetches fresh randomness per sbox group through a valid/ready handshake and writes the substituted bytes back into its internal share registers.
- It sits between the round controller and the linear layer.

---
 rtl/skinny_dom1_pkg.sv | 35 +++
 rtl/skinny_sbox8_dom1_non_pipelined_de.sv | 69 ++++++
 rtl/skinny_sbox_group_dom1.sv | 30 +++
 rtl/skinny_sbox_layer_dom1_ctrl.sv | 139 +++++++++++++
 tb/tb_skinny_sbox_layer_dom1_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/skinny_dom1_pkg.sv
// Shared types, constants and helpers for the DOM1 SKINNY-128 SubCells layer.
//   state_e    : layer controller FSM states
//   STATE_W    : width of one state share
//   BYTE_W     : width of one sbox lane
//   ngrp()     : number of sbox groups for a given core count
//   sbox_perm  : bit permutation applied between S8 rounds (linear, share-wise)
//   sbox_swap  : final bit swap of S8 (linear, share-wise)
package skinny_dom1_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StHold,
    StWb,
    StDone
  } state_e;

  function automatic int unsigned ngrp(input int unsigned num_sbox);
    return 16 / num_sbox;
  endfunction

  // x0->2, x1->6, x2->7, x3->1, x4->3, x5->0, x6->4, x7->5
  function automatic logic [7:0] sbox_perm(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  // Exchange bits 1 and 2
  function automatic logic [7:0] sbox_swap(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

endpackage

// File: rtl/skinny_sbox8_dom1_non_pipelined_de.sv
// Two-share (DOM1) SKINNY-128 S8 core. Each of the four NOR/XOR rounds is one register
// stage, so the output is valid once bi0/bi1/r have been held stable for four clock edges.
// No handshake: the caller owns the hold time.
//   clk      : clock
//   bi0, bi1 : input byte shares
//   r        : refresh mask, bit 2i/2i+1 feed the two AND gates of round i
//   bo0, bo1 : output byte shares
module skinny_sbox8_dom1_non_pipelined_de
  import skinny_dom1_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] bi0,
  input  logic [7:0] bi1,
  input  logic [7:0] r,
  output logic [7:0] bo0,
  output logic [7:0] bo1
);

  localparam int NumRounds = 4;

  logic [7:0] in0   [NumRounds];
  logic [7:0] in1   [NumRounds];
  logic [7:0] mix0  [NumRounds];
  logic [7:0] mix1  [NumRounds];
  logic [7:0] nx0   [NumRounds];
  logic [7:0] nx1   [NumRounds];
  logic [7:0] st0_q [NumRounds];
  logic [7:0] st1_q [NumRounds];

  // One share of a DOM-indep AND: own-domain product plus the masked cross-domain product
  function automatic logic dom_and_share(input logic u_own, input logic v_own,
                                         input logic v_other, input logic rbit);
    return (u_own & v_own) ^ ((u_own & v_other) ^ rbit);
  endfunction

  always_comb begin
    in0[0] = bi0;
    in1[0] = bi1;
    for (int i = 1; i < NumRounds; i++) begin
      in0[i] = st0_q[i-1];
      in1[i] = st1_q[i-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NumRounds; i++) begin
      mix0[i] = in0[i];
      mix1[i] = in1[i];
      // NOR(a, b) = ~a & ~b; inverting share 0 alone inverts the shared value
      mix0[i][0] = in0[i][0] ^ dom_and_share(~in0[i][3], ~in0[i][2], in1[i][2], r[2*i]);
      mix1[i][0] = in1[i][0] ^ dom_and_share(in1[i][3], in1[i][2], ~in0[i][2], r[2*i]);
      mix0[i][4] = in0[i][4] ^ dom_and_share(~in0[i][7], ~in0[i][6], in1[i][6], r[2*i+1]);
      mix1[i][4] = in1[i][4] ^ dom_and_share(in1[i][7], in1[i][6], ~in0[i][6], r[2*i+1]);
      nx0[i] = (i < NumRounds - 1) ? sbox_perm(mix0[i]) : mix0[i];
      nx1[i] = (i < NumRounds - 1) ? sbox_perm(mix1[i]) : mix1[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NumRounds; i++) begin
      st0_q[i] <= nx0[i];
      st1_q[i] <= nx1[i];
    end
  end

  assign bo0 = sbox_swap(st0_q[NumRounds-1]);
  assign bo1 = sbox_swap(st1_q[NumRounds-1]);

endmodule

// File: rtl/skinny_sbox_group_dom1.sv
// NUM_SBOX parallel DOM1 S8 cores fed straight from the controller's input registers.
//   clk        : clock
//   sb0, sb1   : registered input shares, byte k feeds core k
//   rmask      : registered refresh mask, byte k feeds core k
//   bo0, bo1   : output shares, byte k from core k
module skinny_sbox_group_dom1
  import skinny_dom1_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 1
) (
  input  logic                         clk,
  input  logic [BYTE_W*NUM_SBOX-1:0]   sb0,
  input  logic [BYTE_W*NUM_SBOX-1:0]   sb1,
  input  logic [BYTE_W*NUM_SBOX-1:0]   rmask,
  output logic [BYTE_W*NUM_SBOX-1:0]   bo0,
  output logic [BYTE_W*NUM_SBOX-1:0]   bo1
);

  for (genvar k = 0; k < NUM_SBOX; k++) begin : g_sbox
    skinny_sbox8_dom1_non_pipelined_de u_sbox (
      .clk (clk),
      .bi0 (sb0[BYTE_W*k +: BYTE_W]),
      .bi1 (sb1[BYTE_W*k +: BYTE_W]),
      .r   (rmask[BYTE_W*k +: BYTE_W]),
      .bo0 (bo0[BYTE_W*k +: BYTE_W]),
      .bo1 (bo1[BYTE_W*k +: BYTE_W])
    );
  end

endmodule

// File: rtl/skinny_sbox_layer_dom1_ctrl.sv
// Runs the 16-byte SubCells layer of a two-share state through NUM_SBOX DOM1 S8 cores,
// one group of NUM_SBOX bytes at a time, holding core inputs LATENCY cycles per group.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a layer (only looked at when idle)
//   si0, si1            : input state shares, byte i = bits [8i+7:8i]
//   rnd, rnd_valid      : fresh mask per group, byte k to core k
//   rnd_ready           : mask accepted this cycle when rnd_valid is high
//   so0, so1            : result shares (internal share registers)
//   busy                : controller not idle
//   done                : one-cycle pulse, so0/so1 hold the finished layer
module skinny_sbox_layer_dom1_ctrl
  import skinny_dom1_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 1,
  parameter int unsigned LATENCY  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [STATE_W-1:0]          si0,
  input  logic [STATE_W-1:0]          si1,
  input  logic [BYTE_W*NUM_SBOX-1:0]  rnd,
  input  logic                        rnd_valid,
  output logic                        rnd_ready,
  output logic [STATE_W-1:0]          so0,
  output logic [STATE_W-1:0]          so1,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned NGRP  = ngrp(NUM_SBOX);
  localparam int unsigned GW    = BYTE_W * NUM_SBOX;
  localparam int unsigned GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY);

  state_e                   state_q, state_d;
  logic [GRP_W-1:0]         grp_q, grp_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  // Share registers viewed as NGRP groups so group g is simply s0_q[g]
  logic [NGRP-1:0][GW-1:0]  s0_q, s0_d;
  logic [NGRP-1:0][GW-1:0]  s1_q, s1_d;
  logic [GW-1:0]            sb0_q, sb0_d;
  logic [GW-1:0]            sb1_q, sb1_d;
  logic [GW-1:0]            rmask_q, rmask_d;
  logic [GW-1:0]            bo0, bo1;

  // Core inputs come only from registers so they are glitch-free for the whole hold window
  skinny_sbox_group_dom1 #(
    .NUM_SBOX (NUM_SBOX)
  ) u_group (
    .clk   (clk),
    .sb0   (sb0_q),
    .sb1   (sb1_q),
    .rmask (rmask_q),
    .bo0   (bo0),
    .bo1   (bo1)
  );

  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    cnt_d     = cnt_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    sb0_d     = sb0_q;
    sb1_d     = sb1_q;
    rmask_d   = rmask_q;
    rnd_ready = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          s0_d    = si0;
          s1_d    = si1;
          grp_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        rnd_ready = 1'b1;
        if (rnd_valid) begin
          rmask_d = rnd;
          sb0_d   = s0_q[grp_q];
          sb1_d   = s1_q[grp_q];
          cnt_d   = '0;
          state_d = StHold;
        end
      end
      StHold: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          state_d = StWb;
        end
      end
      StWb: begin
        s0_d[grp_q] = bo0;
        s1_d[grp_q] = bo1;
        if (grp_q == GRP_W'(NGRP - 1)) begin
          state_d = StDone;
        end else begin
          grp_d   = grp_q + 1'b1;
          state_d = StFetch;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      grp_q   <= '0;
      cnt_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      sb0_q   <= '0;
      sb1_q   <= '0;
      rmask_q <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      sb0_q   <= sb0_d;
      sb1_q   <= sb1_d;
      rmask_q <= rmask_d;
    end
  end

  assign so0  = s0_q;
  assign so1  = s1_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_skinny_sbox_layer_dom1_ctrl.sv
module tb_skinny_sbox_layer_dom1_ctrl;

  localparam int LAT = 4;
  localparam int NG  = 16;
  localparam logic [127:0] P = 128'h000102030405060708090A0B0C0D0E0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, rnd_valid;
  logic [127:0] si0, si1, rnd_pool;
  logic         rnd_ready, busy, done;
  logic [127:0] so0, so1;
  logic         rnd_ready_2, busy_2, done_2;
  logic [127:0] so0_2, so1_2;
  logic         rnd_ready_4, busy_4, done_4;
  logic [127:0] so0_4, so1_4;
  logic         rnd_ready_16, busy_16, done_16;
  logic [127:0] so0_16, so1_16;

  skinny_sbox_layer_dom1_ctrl #(.NUM_SBOX(1), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .start(start), .si0(si0), .si1(si1), .rnd(rnd_pool[7:0]),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .so0(so0), .so1(so1), .busy(busy),
    .done(done)
  );
  skinny_sbox_layer_dom1_ctrl #(.NUM_SBOX(2), .LATENCY(LAT)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .si0(si0), .si1(si1), .rnd(rnd_pool[15:0]),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_2), .so0(so0_2), .so1(so1_2), .busy(busy_2),
    .done(done_2)
  );
  skinny_sbox_layer_dom1_ctrl #(.NUM_SBOX(4), .LATENCY(LAT)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .si0(si0), .si1(si1), .rnd(rnd_pool[31:0]),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_4), .so0(so0_4), .so1(so1_4), .busy(busy_4),
    .done(done_4)
  );
  skinny_sbox_layer_dom1_ctrl #(.NUM_SBOX(16), .LATENCY(LAT)) u_dut16 (
    .clk(clk), .rst(rst), .start(start), .si0(si0), .si1(si1), .rnd(rnd_pool),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready_16), .so0(so0_16), .so1(so1_16),
    .busy(busy_16), .done(done_16)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Unmasked reference S8, straight from the bitsliced definition
  function automatic logic [7:0] s8(input logic [7:0] v);
    logic [7:0] x;
    x = v;
    for (int r = 0; r < 4; r++) begin
      x = x ^ ((~((x >> 2) | (x >> 3))) & 8'h11);
      if (r < 3) begin
        x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
            ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
      end
    end
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  function automatic logic [127:0] layer(input logic [127:0] p);
    logic [127:0] y;
    y = '0;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = s8(p[8*i +: 8]);
    return y;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Timeline model of the NUM_SBOX=1 instance, checked every cycle at negedge
  logic         m_valid = 1'b0;
  logic         m_busy = 1'b0, m_ready = 1'b0, m_done = 1'b0;
  logic         m_xv = 1'b0, m_zero = 1'b0, m_load = 1'b0;
  int           m_left = 0, m_cd = 0;
  logic [127:0] m_x = '0, m_si0 = '0, m_si1 = '0;
  logic [7:0]   m_rmask = '0;

  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("busy", 128'(busy), 128'(m_busy));
        chk("rnd_ready", 128'(rnd_ready), 128'(m_ready));
        chk("done", 128'(done), 128'(m_done));
        if (m_done) chk("result_at_done", so0 ^ so1, m_x);
        if (!m_busy && m_xv) chk("held_result", so0 ^ so1, m_x);
        if (m_zero) begin
          chk("so0_cleared", so0, '0);
          chk("so1_cleared", so1, '0);
        end
        if (m_load) begin
          chk("so0_loaded", so0, m_si0);
          chk("so1_loaded", so1, m_si1);
        end
        if (m_busy && !m_ready && !m_done) begin
          g = NG - m_left;
          chk("sb0_held", 128'(u_dut.sb0_q), 128'(m_si0[8*g +: 8]));
          chk("sb1_held", 128'(u_dut.sb1_q), 128'(m_si1[8*g +: 8]));
          chk("rmask_held", 128'(u_dut.rmask_q), 128'(m_rmask));
        end
      end
      m_load = 1'b0;
      if (rst) begin
        m_valid = 1'b1; m_busy = 1'b0; m_ready = 1'b0; m_done = 1'b0;
        m_xv = 1'b1; m_x = '0; m_zero = 1'b1;
      end else if (m_valid) begin
        if (!m_busy) begin
          if (start) begin
            m_busy = 1'b1; m_ready = 1'b1; m_left = NG; m_xv = 1'b0; m_zero = 1'b0;
            m_load = 1'b1; m_si0 = si0; m_si1 = si1; m_x = layer(si0 ^ si1);
          end
        end else if (m_done) begin
          m_busy = 1'b0; m_done = 1'b0; m_xv = 1'b1;
        end else if (m_ready) begin
          if (rnd_valid) begin
            m_ready = 1'b0; m_cd = LAT + 1; m_rmask = rnd_pool[7:0];
          end
        end else begin
          m_cd--;
          if (m_cd == 0) begin
            m_left--;
            if (m_left == 0) m_done = 1'b1;
            else m_ready = 1'b1;
          end
        end
      end
    end
  end

  int           t_lat, t_ready, t_done, t_lat2, t_lat4, t_lat16;
  logic [127:0] t_first0, t_first1;

  // Window c: outputs belong to cycle c after the start-sampling edge, inputs set here
  // are sampled at the edge that ends cycle c.
  task automatic run_op(input int stall_at, input int stall_len, input int xs_a,
                        input int xs_b, input logic [127:0] alt, input int rst_at,
                        input int post);
    logic [127:0] keep0;
    t_lat = -1; t_ready = 0; t_done = 0; t_lat2 = -1; t_lat4 = -1; t_lat16 = -1;
    keep0 = si0;
    start = 1'b1; rnd_valid = 1'b1; rnd_pool = rand128();
    @(posedge clk); #2;
    start = 1'b0;
    t_first0 = so0; t_first1 = so1;
    for (int c = 1; c <= 400; c++) begin
      if (rnd_ready) t_ready++;
      if (done) begin
        t_done++;
        if (t_lat < 0) t_lat = c;
      end
      if (done_2 && t_lat2 < 0) t_lat2 = c;
      if (done_4 && t_lat4 < 0) t_lat4 = c;
      if (done_16 && t_lat16 < 0) t_lat16 = c;
      if (c == rst_at + 1) begin
        rst = 1'b0;
        chk("rst_busy", 128'(busy), '0);
        chk("rst_done", 128'(done), '0);
        chk("rst_rnd_ready", 128'(rnd_ready), '0);
        chk("rst_so0", so0, '0);
        chk("rst_so1", so1, '0);
        break;
      end
      if (t_lat >= 0 && c >= t_lat + post) break;
      rnd_valid = !(c >= stall_at && c < stall_at + stall_len);
      rnd_pool  = rand128();
      start     = (c == xs_a || c == xs_b);
      si0       = start ? alt : keep0;
      rst       = (c == rst_at);
      @(posedge clk); #2;
    end
    start = 1'b0; rnd_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] q, n0, n1;
    rst = 1'b1; start = 1'b0; rnd_valid = 1'b1; si0 = '0; si1 = '0; rnd_pool = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_busy", 128'(busy), '0);
    chk("reset_done", 128'(done), '0);
    chk("reset_rnd_ready", 128'(rnd_ready), '0);
    chk("reset_so0", so0, '0);
    chk("reset_so1", so1, '0);
    rst = 1'b0;
    @(posedge clk); #2;

    // Zero state: every byte becomes S8(0) = 0x65
    si0 = '0; si1 = '0;
    run_op(-100, 0, -1, -1, '0, -1, 2);
    chk_int("zero_latency", t_lat, 97);
    chk_int("zero_ready_cycles", t_ready, 16);
    chk_int("zero_done_pulses", t_done, 1);
    chk("zero_result", so0 ^ so1, {16{8'h65}});

    // Every byte 0x01 under a random mask: S8(1) = 0x4C
    si1 = rand128(); si0 = si1 ^ {16{8'h01}};
    run_op(-100, 0, -1, -1, '0, -1, 2);
    chk_int("one_latency", t_lat, 97);
    chk("one_result", so0 ^ so1, {16{8'h4C}});

    // Masked P through all four core counts
    si1 = rand128(); si0 = si1 ^ P;
    run_op(-100, 0, -1, -1, '0, -1, 2);
    chk_int("p_latency_n1", t_lat, 97);
    chk_int("p_latency_n2", t_lat2, 49);
    chk_int("p_latency_n4", t_lat4, 25);
    chk_int("p_latency_n16", t_lat16, 7);
    chk("p_result_n1", so0 ^ so1, layer(P));
    chk("p_result_n2", so0_2 ^ so1_2, layer(P));
    chk("p_result_n4", so0_4 ^ so1_4, layer(P));
    chk("p_result_n16", so0_16 ^ so1_16, layer(P));

    // rnd_valid low for the first 5 cycles of group 3's fetch
    run_op(19, 5, -1, -1, '0, -1, 2);
    chk_int("stall_latency", t_lat, 102);
    chk_int("stall_ready_cycles", t_ready, 21);
    chk("stall_result", so0 ^ so1, layer(P));

    // start pulses while busy are ignored
    run_op(-100, 0, 10, 50, rand128(), -1, 5);
    chk_int("busy_start_latency", t_lat, 97);
    chk_int("busy_start_done_pulses", t_done, 1);
    chk("busy_start_result", so0 ^ so1, layer(P));

    // Reset in the middle of a layer, then a clean layer
    run_op(-100, 0, -1, -1, '0, 40, 0);
    chk_int("aborted_done_pulses", t_done, 0);
    q = rand128(); si1 = rand128(); si0 = si1 ^ q;
    run_op(-100, 0, -1, -1, '0, -1, 0);
    chk_int("after_rst_latency", t_lat, 97);
    chk("after_rst_result", so0 ^ so1, layer(q));

    // New start in the cycle right after done
    @(posedge clk); #2;
    n1 = rand128(); n0 = n1 ^ P; si0 = n0; si1 = n1;
    run_op(-100, 0, -1, -1, '0, -1, 2);
    chk("b2b_so0_loaded", t_first0, n0);
    chk("b2b_so1_loaded", t_first1, n1);
    chk_int("b2b_latency", t_lat, 97);
    chk("b2b_result", so0 ^ so1, layer(P));

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
